sort_frame_collector: RTL and testbench
=======================================

Name: sort_frame_collector

Overview:
- Upstream feeder for the combinational bubble sorter.
- Accepts a serial stream of WIDTH-bit elements over a valid/ready handshake and assembles frames of N elements in a ping-pong (two-bank) buffer.
- Presents each completed frame as a flat N*WIDTH vector, plus a real-element count, to the sorter/consumer over a second valid/ready handshake.
- Short frames (terminated by in_last) are padded with PAD_VAL so that pad entries sort to the top.

Parameters:
- N, 5, elements per frame (N >= 2).
- WIDTH, 8, bits per element.
- PAD_VAL, {WIDTH{1'b1}}, value written into unused slots of a short frame.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data/in_last valid.
- in_ready  output  1  collector can accept an element this cycle.
- in_data  input  WIDTH  element.
- in_last  input  1  final element of the current frame.
- out_valid  output  1  completed frame available.
- out_ready  input  1  consumer takes the frame this cycle.
- out_frame  output  N*WIDTH  element i at bits [i*WIDTH +: WIDTH].
- out_count  output  $clog2(N+1)  number of real (non-pad) elements, range 1..N.

Behaviour:
- Reset (async, rst_n=0):
  - Both banks, counts, full flags, idx, wr_bank and rd_bank clear to 0.
  - Outputs: out_valid=0, out_frame=0, out_count=0, in_ready=1.
- Storage:
  - bank[0..1] each hold N x WIDTH data and a count.
  - full[1:0] holds per-bank full flags.
  - wr_bank and rd_bank are 1-bit pointers.
  - idx ranges 0..N-1.
- Write FSM:
  - COLLECT:
    - in_ready = ~full[wr_bank].
    - Accept when in_valid & in_ready: write bank[wr_bank][idx] = in_data.
  - Close condition: accept & (in_last | idx==N-1).
    - Same edge: full[wr_bank]<=1; count<=idx+1; slots idx+1..N-1 <= PAD_VAL; idx<=0; wr_bank toggles.
  - Otherwise on accept: idx<=idx+1.
  - STALL: state whenever full[wr_bank]=1. in_ready=0, inputs ignored, idx held. Return to COLLECT when the consumer releases that bank.
- Read side:
  - out_valid = full[rd_bank].
  - out_frame and out_count are driven registered from bank[rd_bank].
  - Release: out_valid & out_ready clears full[rd_bank] and toggles rd_bank.
  - out_frame/out_count must remain stable while out_valid=1 and out_ready=0.
- Latency and throughput:
  - A frame appears (out_valid=1) the cycle after its closing element is accepted.
  - With out_ready held at 1, in_ready never drops: sustained 1 element/cycle.
- Simultaneous events:
  - Close on one bank and release of the other in the same cycle: both take effect.
  - Release of bank B in the same cycle that wr_bank==B: in_ready reflects the pre-edge flag, so in_ready rises next cycle. No combinational path from out_ready to in_ready.
- Boundaries:
  - in_last on the first element: count=1, slots 1..N-1 = PAD_VAL.
  - in_last on element N-1 equals an auto-close; no double close.
  - Both banks full: in_ready=0 until a release.
- Reset mid-frame: a partial frame is discarded. No partial output is ever produced.
- in_valid while in_ready=0: the element is not consumed, and the source must hold it.

Test Plan:
- Full frame:
  - Stimulus: stream 9,3,7,1,5 with out_ready=1.
  - Required: out_valid one cycle after element 5; out_frame slots 0..4 = 9,3,7,1,5; out_count=5; in_ready stays 1.
- Short frame:
  - Stimulus: 4,2 with in_last on 2.
  - Required: slots = 4,2,FF,FF,FF; out_count=2; next frame starts at slot 0.
- Backpressure:
  - Stimulus: out_ready=0; stream 10 elements.
  - Required: two frames buffered; 11th element sees in_ready=0; first frame is 1..5 held stable.
  - Then: pulse out_ready one cycle → frame 6..10 presented, in_ready=1 the following cycle.
- Back-to-back:
  - Stimulus: 20 consecutive elements 0..19 with out_ready=1.
  - Required: four frames in order, no in_ready deassertion, no lost or duplicated elements.
- Single-element frames:
  - Stimulus: in_last on every element A,B,C.
  - Required: three frames with out_count=1, slot0 = A,B,C, remaining slots FF.
- Async reset:
  - Stimulus: assert rst_n=0 after 3 elements of a frame.
  - Required: out_valid=0 immediately (without a clock edge); after release, the next frame starts at slot 0 with no remnants.

Source files
------------

// File: rtl/sort_frame_collector_if.sv
// Handshake bundle between an element source/frame consumer and sort_frame_collector.
//   in_valid/in_ready/in_data/in_last    serial element stream into the collector
//   out_valid/out_ready/out_frame/out_count  completed frame toward the sorter
// master: the environment side (element source and frame consumer).
// slave : the collector.
interface sort_frame_collector_if #(
  parameter int unsigned N     = 5,
  parameter int unsigned WIDTH = 8
);
  logic                       in_valid;
  logic                       in_ready;
  logic [WIDTH-1:0]           in_data;
  logic                       in_last;
  logic                       out_valid;
  logic                       out_ready;
  logic [N*WIDTH-1:0]         out_frame;
  logic [$clog2(N+1)-1:0]     out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_frame, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_frame, out_count
  );
endinterface

// File: rtl/sort_frame_collector.sv
// Frame collector feeding the combinational bubble sorter.
// Assembles a serial WIDTH-bit element stream into N-element frames held in a
// two-bank (ping-pong) buffer. Short frames (closed by in_last) are padded with
// PAD_VAL so that pad slots sort to the top.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    sort_frame_collector_if.slave
//          in_*  : element stream (valid/ready, data, last)
//          out_* : frame stream (valid/ready, flat frame, real-element count)
module sort_frame_collector #(
  parameter int unsigned    N       = 5,
  parameter int unsigned    WIDTH   = 8,
  parameter logic [WIDTH-1:0] PAD_VAL = {WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sort_frame_collector_if.slave bus
);

  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CntW = $clog2(N + 1);

  typedef enum logic [0:0] {StCollect, StStall} state_e;

  logic [WIDTH-1:0] mem_q [2][N];
  logic [WIDTH-1:0] mem_d [2][N];
  logic [CntW-1:0]  cnt_q [2];
  logic [CntW-1:0]  cnt_d [2];
  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  state_e           state_q, state_d;

  logic accept;
  logic close;
  logic rel;

  assign accept = bus.in_valid & bus.in_ready;
  assign close  = accept & (bus.in_last | (idx_q == IdxW'(N - 1)));
  assign rel    = full_q[rd_bank_q] & bus.out_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StCollect;
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      idx_q     <= '0;
      for (int b = 0; b < 2; b++) begin
        cnt_q[b] <= '0;
        for (int i = 0; i < N; i++) begin
          mem_q[b][i] <= '0;
        end
      end
    end else begin
      state_q   <= state_d;
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      mem_q     <= mem_d;
    end
  end

  // Buffer, pointer and flag next-state
  always_comb begin
    mem_d     = mem_q;
    cnt_d     = cnt_q;
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    idx_d     = idx_q;

    if (accept) begin
      for (int i = 0; i < N; i++) begin
        if (i == int'(idx_q)) begin
          mem_d[wr_bank_q][i] = bus.in_data;
        end else if (close && (i > int'(idx_q))) begin
          mem_d[wr_bank_q][i] = PAD_VAL;
        end
      end
      if (close) begin
        full_d[wr_bank_q] = 1'b1;
        cnt_d[wr_bank_q]  = CntW'(idx_q) + CntW'(1);
        idx_d             = '0;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        idx_d = idx_q + IdxW'(1);
      end
    end

    // A close can never hit the bank being released: closing needs it empty,
    // releasing needs it full.
    if (rel) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  // FSM next state: stall whenever the bank to be written next is still full.
  // Registered, so a release only reopens in_ready on the following cycle.
  always_comb begin
    state_d = full_d[wr_bank_d] ? StStall : StCollect;
  end

  // Outputs
  always_comb begin
    bus.in_ready  = (state_q == StCollect);
    bus.out_valid = full_q[rd_bank_q];
    bus.out_count = cnt_q[rd_bank_q];
    bus.out_frame = '0;
    for (int i = 0; i < N; i++) begin
      bus.out_frame[i*WIDTH +: WIDTH] = mem_q[rd_bank_q][i];
    end
  end

endmodule

// File: tb/tb_sort_frame_collector.sv
module tb_sort_frame_collector;

  localparam int unsigned N  = 5;
  localparam int unsigned W  = 8;
  localparam logic [W-1:0] PAD = 8'hFF;

  logic clk;
  logic rst_n;

  sort_frame_collector_if #(.N(N), .WIDTH(W)) bus ();

  sort_frame_collector #(
    .N      (N),
    .WIDTH  (W),
    .PAD_VAL(PAD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_run;
  int n_fail;
  int stall_cnt;
  int timeouts;

  // Reference model: elements accumulate into a list; a frame is emitted when
  // in_last is seen or the list reaches N, padded out to N slots.
  logic [W-1:0]     cur [N];
  int               cur_n;
  logic [N*W-1:0]   exp_f [$];
  int               exp_c [$];
  logic [N*W-1:0]   got_f [$];
  int               got_c [$];

  function automatic void model_push(input logic [W-1:0] d, input logic last);
    logic [N*W-1:0] f;
    cur[cur_n] = d;
    cur_n++;
    if (last || cur_n == N) begin
      for (int i = 0; i < N; i++) f[i*W +: W] = (i < cur_n) ? cur[i] : PAD;
      exp_f.push_back(f);
      exp_c.push_back(cur_n);
      cur_n = 0;
    end
  endfunction

  function automatic void model_clear();
    cur_n = 0;
    exp_f.delete();
    exp_c.delete();
    got_f.delete();
    got_c.delete();
  endfunction

  // One clock: observe handshakes on the falling edge, then step past the rising edge.
  task automatic tick(output bit acc, output bit rel);
    @(negedge clk);
    acc = bus.in_valid && bus.in_ready;
    rel = bus.out_valid && bus.out_ready;
    if (bus.in_valid && !bus.in_ready) stall_cnt++;
    if (acc) model_push(bus.in_data, bus.in_last);
    if (rel) begin
      got_f.push_back(bus.out_frame);
      got_c.push_back(int'(bus.out_count));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input logic last);
    bit a, r;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    a = 1'b0;
    for (int k = 0; k < 64 && !a; k++) tick(a, r);
    if (!a) timeouts++;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int cycles);
    bit a, r;
    for (int k = 0; k < cycles; k++) tick(a, r);
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    model_clear();
    #12;
    n_run++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    end
    n_run++;
    if (bus.out_frame !== '0) begin
      n_fail++; $display("FAIL reset_out_frame: got %h expected 0", bus.out_frame);
    end
    n_run++;
    if (bus.out_count !== '0) begin
      n_fail++; $display("FAIL reset_out_count: got %0d expected 0", bus.out_count);
    end
    n_run++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_frame();
    logic [W-1:0] v [5] = '{8'd9, 8'd3, 8'd7, 8'd1, 8'd5};
    model_clear();
    stall_cnt = 0;
    timeouts = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(v[i], 1'b0);
    n_run++;
    if (bus.out_valid !== 1'b1 || exp_f.size() != 1) begin
      n_fail++;
      $display("FAIL full_latency: got out_valid %b frames %0d expected 1 and 1",
               bus.out_valid, exp_f.size());
    end else begin
      n_run++;
      if (bus.out_frame !== exp_f[0] || int'(bus.out_count) != 5) begin
        n_fail++;
        $display("FAIL full_frame: got %h/%0d expected %h/5", bus.out_frame, bus.out_count,
                 exp_f[0]);
      end
    end
    idle(3);
    n_run++;
    if (stall_cnt != 0 || timeouts != 0) begin
      n_fail++; $display("FAIL full_in_ready: got %0d stalls expected 0", stall_cnt);
    end
    n_run++;
    if (got_f.size() != exp_f.size()) begin
      n_fail++; $display("FAIL full_count: got %0d frames expected %0d", got_f.size(), exp_f.size());
    end
    for (int i = 0; i < got_f.size() && i < exp_f.size(); i++) begin
      n_run++;
      if (got_f[i] !== exp_f[i] || got_c[i] != exp_c[i]) begin
        n_fail++;
        $display("FAIL full_data[%0d]: got %h/%0d expected %h/%0d", i, got_f[i], got_c[i],
                 exp_f[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_short_frame();
    model_clear();
    timeouts = 0;
    bus.out_ready = 1'b1;
    send(8'd4, 1'b0);
    send(8'd2, 1'b1);
    n_run++;
    if (bus.out_valid !== 1'b1 || int'(bus.out_count) != 2 ||
        bus.out_frame !== {PAD, PAD, PAD, 8'd2, 8'd4}) begin
      n_fail++;
      $display("FAIL short_frame: got %b %h/%0d expected 1 ffffff0204/2", bus.out_valid,
               bus.out_frame, bus.out_count);
    end
    send(8'd8, 1'b1);
    idle(3);
    n_run++;
    if (got_f.size() != exp_f.size() || timeouts != 0) begin
      n_fail++; $display("FAIL short_count: got %0d frames expected %0d", got_f.size(), exp_f.size());
    end
    for (int i = 0; i < got_f.size() && i < exp_f.size(); i++) begin
      n_run++;
      if (got_f[i] !== exp_f[i] || got_c[i] != exp_c[i]) begin
        n_fail++;
        $display("FAIL short_data[%0d]: got %h/%0d expected %h/%0d", i, got_f[i], got_c[i],
                 exp_f[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit a, r;
    model_clear();
    timeouts = 0;
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 10; i++) send(W'(i), 1'b0);
    n_run++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_both_full: got in_ready %b out_valid %b expected 0 1", bus.in_ready,
               bus.out_valid);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd11;
    bus.in_last  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_run++;
      if (bus.out_frame !== exp_f[0] || int'(bus.out_count) != 5) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got %h/%0d expected %h/5", k, bus.out_frame, bus.out_count,
                 exp_f[0]);
      end
      tick(a, r);
      n_run++;
      if (a) begin
        n_fail++; $display("FAIL bp_accept[%0d]: got accept 1 expected 0", k);
      end
    end
    bus.out_ready = 1'b1;
    tick(a, r);
    bus.out_ready = 1'b0;
    n_run++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1 || bus.out_frame !== exp_f[1]) begin
      n_fail++;
      $display("FAIL bp_release: got in_ready %b out_valid %b frame %h expected 1 1 %h",
               bus.in_ready, bus.out_valid, bus.out_frame, exp_f[1]);
    end
    a = 1'b0;
    for (int k = 0; k < 8 && !a; k++) tick(a, r);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    idle(4);
    n_run++;
    if (got_f.size() != 3 || exp_f.size() != 3 || timeouts != 0) begin
      n_fail++; $display("FAIL bp_count: got %0d frames expected 3", got_f.size());
    end
    for (int i = 0; i < got_f.size() && i < exp_f.size(); i++) begin
      n_run++;
      if (got_f[i] !== exp_f[i] || got_c[i] != exp_c[i]) begin
        n_fail++;
        $display("FAIL bp_data[%0d]: got %h/%0d expected %h/%0d", i, got_f[i], got_c[i],
                 exp_f[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    model_clear();
    stall_cnt = 0;
    timeouts = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) send(W'(i), 1'b0);
    idle(3);
    n_run++;
    if (stall_cnt != 0 || timeouts != 0) begin
      n_fail++; $display("FAIL b2b_in_ready: got %0d stalls expected 0", stall_cnt);
    end
    n_run++;
    if (got_f.size() != 4 || exp_f.size() != 4) begin
      n_fail++; $display("FAIL b2b_count: got %0d frames expected 4", got_f.size());
    end
    for (int i = 0; i < got_f.size() && i < exp_f.size(); i++) begin
      n_run++;
      if (got_f[i] !== exp_f[i] || got_c[i] != exp_c[i]) begin
        n_fail++;
        $display("FAIL b2b_data[%0d]: got %h/%0d expected %h/%0d", i, got_f[i], got_c[i],
                 exp_f[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_single_element();
    model_clear();
    timeouts = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(W'($urandom_range(0, 254)), 1'b1);
    idle(3);
    n_run++;
    if (got_f.size() != 3 || exp_f.size() != 3 || timeouts != 0) begin
      n_fail++; $display("FAIL single_count: got %0d frames expected 3", got_f.size());
    end
    for (int i = 0; i < got_f.size() && i < exp_f.size(); i++) begin
      n_run++;
      if (got_f[i] !== exp_f[i] || got_c[i] != 1) begin
        n_fail++;
        $display("FAIL single_data[%0d]: got %h/%0d expected %h/1", i, got_f[i], got_c[i],
                 exp_f[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    model_clear();
    timeouts = 0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(W'(8'h40 + i), 1'b0);
    n_run++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL arst_pre_valid: got %b expected 1", bus.out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_run++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_frame !== '0) begin
      n_fail++;
      $display("FAIL arst_immediate: got out_valid %b in_ready %b frame %h expected 0 1 0",
               bus.out_valid, bus.in_ready, bus.out_frame);
    end
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(8'd7, 1'b0);
    send(8'd8, 1'b1);
    idle(3);
    n_run++;
    if (got_f.size() != 1 || exp_f.size() != 1 || timeouts != 0) begin
      n_fail++; $display("FAIL arst_count: got %0d frames expected 1", got_f.size());
    end
    for (int i = 0; i < got_f.size() && i < exp_f.size(); i++) begin
      n_run++;
      if (got_f[i] !== exp_f[i] || got_c[i] != exp_c[i]) begin
        n_fail++;
        $display("FAIL arst_data: got %h/%0d expected %h/%0d", got_f[i], got_c[i], exp_f[i],
                 exp_c[i]);
      end
    end
  endtask

  task automatic test_random();
    bit a, r, hold, was_valid;
    logic [N*W-1:0] prev_f;
    logic [$clog2(N+1)-1:0] prev_c;
    int bad_hold;
    model_clear();
    bad_hold = 0;
    hold = 1'b0;
    bus.in_valid = 1'b0;
    a = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (hold && (bus.out_valid !== 1'b1 || bus.out_frame !== prev_f ||
                   bus.out_count !== prev_c)) begin
        bad_hold++;
      end
      if (a || !bus.in_valid) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.in_data  = W'($urandom);
        bus.in_last  = ($urandom_range(0, 5) == 0);
      end
      bus.out_ready = ($urandom_range(0, 2) != 0);
      was_valid = bus.out_valid;
      prev_f = bus.out_frame;
      prev_c = bus.out_count;
      tick(a, r);
      hold = was_valid && !r;
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 16 && bus.in_valid && !a; k++) tick(a, r);
    bus.in_valid = 1'b0;
    idle(4);
    n_run++;
    if (bad_hold != 0) begin
      n_fail++; $display("FAIL rand_stable: got %0d unstable cycles expected 0", bad_hold);
    end
    n_run++;
    if (got_f.size() != exp_f.size() || exp_f.size() == 0) begin
      n_fail++; $display("FAIL rand_count: got %0d frames expected %0d", got_f.size(), exp_f.size());
    end
    for (int i = 0; i < got_f.size() && i < exp_f.size(); i++) begin
      n_run++;
      if (got_f[i] !== exp_f[i] || got_c[i] != exp_c[i]) begin
        n_fail++;
        $display("FAIL rand_data[%0d]: got %h/%0d expected %h/%0d", i, got_f[i], got_c[i],
                 exp_f[i], exp_c[i]);
      end
    end
  endtask

  initial begin
    n_run = 0;
    n_fail = 0;
    stall_cnt = 0;
    timeouts = 0;
    cur_n = 0;
    test_reset();
    test_full_frame();
    test_short_frame();
    test_backpressure();
    test_back_to_back();
    test_single_element();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
